// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store sequencer between the M stage and a
// 32-bit word-addressed data memory with a valid/ready handshake. Stores are
// narrowed into replicated byte lanes with byte enables; loads are extracted
// from the returned word and zero/sign-extended. Misalignment, reserved size
// and timeout are reported through resp_err.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [1:0]  off_q, off_d;
    logic [29:0] waddr_q, waddr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        bad_req;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic        timeout_hit;

    // Decode the incoming request: legality, byte enables and lane-replicated data.
    always_comb begin
        bad_req  = (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_addr[0])
                 | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
        be_in    = 4'b1111;
        wdata_in = req_wdata;
        case (req_size)
            2'b00: begin
                be_in    = 4'b0001 << req_addr[1:0];
                wdata_in = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_in    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{req_wdata[15:0]}};
            end
            default: begin
                be_in    = 4'b1111;
                wdata_in = req_wdata;
            end
        endcase
    end

    // Extract the addressed field from the returned word and extend it.
    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (off_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   ld_ext = {{24{sign_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{sign_q & ld_half[15]}}, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Count reaches TIMEOUT at the end of the current cycle.
    always_comb begin
        timeout_hit = (({16'd0, cnt_q} + 32'd1) >= 32'(TIMEOUT));
    end

    // Next-state, request capture, timeout counter and response capture.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sign_d  = sign_q;
        off_d   = off_q;
        waddr_d = waddr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    sign_d  = req_sign;
                    off_d   = req_addr[1:0];
                    waddr_d = req_addr[31:2];
                    be_d    = be_in;
                    wdata_d = wdata_in;
                    rdata_d = '0;
                    err_d   = bad_req;
                    state_d = bad_req ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 16'd1;
                if (mem_ready) begin
                    state_d = we_q ? RESP : WAIT_R;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            WAIT_R: begin
                cnt_d = cnt_q + 16'd1;
                if (mem_rvalid) begin
                    rdata_d = ld_ext;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= '0;
            sign_q  <= 1'b0;
            off_q   <= '0;
            waddr_q <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            off_q   <= off_d;
            waddr_q <= waddr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from state and gated registers, so reset zeroes them at once.
    always_comb begin
        req_ready  = (state_q == IDLE);
        mem_valid  = (state_q == ISSUE);
        mem_we     = mem_valid & we_q;
        mem_addr   = mem_valid ? {waddr_q, 2'b00} : '0;
        mem_be     = mem_valid ? be_q : '0;
        mem_wdata  = mem_valid ? wdata_q : '0;
        resp_valid = (state_q == RESP);
        resp_rdata = resp_valid ? rdata_q : '0;
        resp_err   = resp_valid & err_q;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access unit sitting between the pipeline's M stage and a 32-bit word-addressed data memory port with a valid/ready handshake. It works in the opposite direction to the immediate extender. On stores it narrows sub-word write data into replicated byte lanes with byte enables. On loads it extracts the addressed byte or halfword from the returned word and zero- or sign-extends it to 32 bits. A small FSM sequences each access, reports misalignment and timeout, and holds `req_ready` low so the pipeline stalls while the access is in flight.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent in ISSUE plus WAIT_R before the access aborts with an error; legal range 1–65535.
- `clk`  in  1  single clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-low; low forces IDLE immediately.
- `req_valid`  in  1  M-stage access request.
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid` and `req_ready` are both high at a clock edge.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- `req_sign`  in  1  loads only: 1 = sign-extend (lb/lh), 0 = zero-extend (lbu/lhu).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; only the low 8/16 bits are used for byte/halfword.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  qualified by `resp_valid`; set on misaligned, reserved-size or timeout.
- `mem_valid`  out  1  memory request.
- `mem_ready`  in  1  memory accepts the request.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  32  `{addr[31:2],2'b00}`.
- `mem_be`  out  4  byte enables; bit k covers `mem_wdata[8k+7:8k]`.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read word.

## Operation
- States: IDLE, ISSUE, WAIT_R, RESP.
- IDLE:
  - Accepted request with size 11, a halfword with `addr[0]=1`, or a word with `addr[1:0]≠0` → RESP with err=1; no memory transaction.
  - Any other accepted request → ISSUE.
  - Request fields are registered on acceptance.
- ISSUE: `mem_valid`=1 with address, we, be and wdata held stable until `mem_ready`. On `mem_ready`:
  - store → RESP;
  - load → WAIT_R.
- WAIT_R: wait for `mem_rvalid`, then capture the extended data and go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- Lanes are little-endian; k=`addr[1:0]`.
  - Byte: `mem_be`=1<<k, `mem_wdata`={4{wdata[7:0]}}.
  - Halfword: `mem_be`=0011 if `addr[1]`=0, else 1100; `mem_wdata`={2{wdata[15:0]}}.
  - Word: `mem_be`=1111, `mem_wdata`=wdata.
  - Loads drive `mem_be` exactly as stores do.
- Load extraction:
  - Byte: `rdata[8k+7:8k]`.
  - Halfword: `rdata[16·addr[1]+15 : 16·addr[1]]`.
  - Word: `rdata` unchanged.
  - Fill with the MSB of the extracted field when `req_sign`=1, else zeros. `req_sign` is ignored for words.
- Timeout: a 16-bit counter clears on entry to ISSUE and increments every cycle in ISSUE or WAIT_R.
  - When the count reaches `TIMEOUT` with no completing handshake → RESP with err=1, rdata=0.
  - If the handshake and the timeout occur on the same cycle, the handshake wins.
- `mem_rvalid` outside WAIT_R and `mem_ready` outside ISSUE are ignored.

## Timing
- Reset values: `req_ready`=1, all other outputs 0, state IDLE, counter 0.
- Asserting `reset` mid-access drops `mem_valid` combinationally-fast (async); the access is abandoned with no response.
- Latency from the acceptance edge T:
  - `mem_valid` high from T.
  - Store with `mem_ready` in the first ISSUE cycle: `resp_valid` at T+1.
  - Load with `mem_ready` at T and `mem_rvalid` one cycle later: `resp_valid` at T+2.
  - Misaligned or reserved-size request: `resp_valid` at T, err=1.
- Outputs are registered or decoded from state; no combinational path from `mem_rdata` to `resp_rdata`.
- Back-to-back accesses: the next request can be accepted the cycle after RESP.

## Test plan
- Store byte: addr 0x1003, wdata 0x000000A5 → `mem_be`=1000, `mem_wdata`=0xA5A5A5A5, `mem_addr`=0x1000, `resp_valid` one cycle, err=0.
- Load halfword, signed: addr 0x2002, `mem_rdata`=0x8001_7FFF → `resp_rdata`=0xFFFF8001; same access with `req_sign`=0 → 0x00008001.
- Load byte, signed: addr 0x0001, `mem_rdata`=0x0000_7F00 → 0x0000007F; `mem_ready` delayed 3 cycles → `mem_valid` held with stable outputs, `resp_valid` delayed accordingly.
- Misaligned word at 0x0006 and reserved size 11 → no `mem_valid` pulse, `resp_valid` with err=1 in the cycle after acceptance.
- Timeout, `TIMEOUT`=4, `mem_ready` never asserted → err=1 after exactly 4 ISSUE cycles; a second run with `mem_ready` on the 4th cycle → err=0.
- `reset` low while in WAIT_R → all outputs zero immediately, `req_ready`=1; a late `mem_rvalid` after reset produces no `resp_valid`.
